// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in EXE; LO = quotient, HI = remainder.
// Latency: 1 launch cycle (IDLE) + 32 RUN cycles, then DONE. Divide-by-zero: IDLE + DZERO, then DONE.
// Backpressure: stallreq_div holds the pipeline until DONE; dropping div_start or raising flush aborts.
//
// Ports:
//   cpu_clk_50M, cpu_rst_n   clock, asynchronous active-low reset
//   div_start, div_signed    operation request (held for the whole stall), signed select
//   div_src1, div_src2       dividend, divisor (sampled once, at launch)
//   flush                    cancels any operation in progress
//   stallreq_div             stall request to the EXE stage
//   div_ready                one-cycle pulse while div_hi/div_lo carry a fresh result
//   div_hi, div_lo           remainder, quotient (registered, hold until the next result)
module div_unit #(
   parameter int DW    = 32,
   parameter int CNT_W = 6
) (
   input  logic          cpu_clk_50M,
   input  logic          cpu_rst_n,
   input  logic          div_start,
   input  logic          div_signed,
   input  logic [DW-1:0] div_src1,
   input  logic [DW-1:0] div_src2,
   input  logic          flush,
   output logic          stallreq_div,
   output logic          div_ready,
   output logic [DW-1:0] div_hi,
   output logic [DW-1:0] div_lo
);

   typedef enum logic [1:0] {IDLE, DZERO, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*DW:0]    sh_q, sh_d;        // {partial remainder (DW+1), dividend/quotient (DW)}
   logic [DW-1:0]    dvsr_q, dvsr_d;    // divisor magnitude
   logic             negq_q, negq_d;    // quotient must be negated
   logic             negr_q, negr_d;    // remainder must be negated
   logic [DW-1:0]    hi_q, hi_d;
   logic [DW-1:0]    lo_q, lo_d;

   logic             go;
   logic             src1_neg, src2_neg;
   logic [DW-1:0]    mag1, mag2;
   logic [2*DW:0]    sh_shift, step_res;
   logic [DW:0]      trial;
   logic [DW-1:0]    quot, rem, quot_fix, rem_fix;

   assign go       = div_start & ~flush;
   assign src1_neg = div_signed & div_src1[DW-1];
   assign src2_neg = div_signed & div_src2[DW-1];
   // 0x8000_0000 negates to itself, which read as unsigned is exactly 2^31.
   assign mag1     = src1_neg ? -div_src1 : div_src1;
   assign mag2     = src2_neg ? -div_src2 : div_src2;

   // One restoring step: shift, trial-subtract from the upper half, keep it if non-negative.
   always_comb begin
      sh_shift = sh_q << 1;
      trial    = sh_shift[2*DW:DW] - {1'b0, dvsr_q};
      step_res = sh_shift;
      if (!trial[DW]) begin
         step_res[2*DW:DW] = trial;
         step_res[0]       = 1'b1;
      end
   end

   assign quot     = step_res[DW-1:0];
   assign rem      = step_res[2*DW-1:DW];
   assign quot_fix = negq_q ? -quot : quot;
   assign rem_fix  = negr_q ? -rem  : rem;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      dvsr_d  = dvsr_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (!go) begin
         // Abort: results are left untouched.
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d  = '0;
               dvsr_d = mag2;
               negq_d = src1_neg ^ src2_neg;
               negr_d = src1_neg;
               if (div_src2 == '0) begin
                  // Keep the raw dividend: it is returned as HI unchanged.
                  state_d = DZERO;
                  sh_d    = {{(DW+1){1'b0}}, div_src1};
               end else begin
                  state_d = RUN;
                  sh_d    = {{(DW+1){1'b0}}, mag1};
               end
            end
            DZERO: begin
               state_d = DONE;
               lo_d    = '1;
               hi_d    = sh_q[DW-1:0];
            end
            RUN: begin
               sh_d  = step_res;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DW-1)) begin
                  state_d = DONE;
                  lo_d    = quot_fix;
                  hi_d    = rem_fix;
               end
            end
            default: state_d = IDLE;   // DONE
         endcase
      end
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         dvsr_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         dvsr_q  <= dvsr_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign div_ready    = (state_q == DONE);
   assign div_hi       = hi_q;
   assign div_lo       = lo_q;
   // Gated by reset so the request drops the moment reset is asserted,
   // even though div_start may still be high.
   assign stallreq_div = cpu_rst_n & go & (state_q != DONE);

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        sgn;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        flush;
   logic        stall;
   logic        ready;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_lo = '0;
   logic [31:0] last_hi = '0;

   div_unit #(.DW(32), .CNT_W(6)) dut (
      .cpu_clk_50M  (clk),
      .cpu_rst_n    (rst_n),
      .div_start    (start),
      .div_signed   (sgn),
      .div_src1     (src1),
      .div_src2     (src2),
      .flush        (flush),
      .stallreq_div (stall),
      .div_ready    (ready),
      .div_hi       (hi),
      .div_lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division, C-style truncation toward zero.
   function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Called in the low clock phase of an IDLE cycle; returns in the low phase
   // of the cycle after DONE. keep=1 leaves div_start high for a back-to-back op.
   task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b, input bit keep);
      logic [31:0] eq;
      logic [31:0] er;
      int          stalls;
      bit          seen;
      ref_div(s, a, b, eq, er);
      sgn    = s;
      src1   = a;
      src2   = b;
      start  = 1'b1;
      stalls = 0;
      seen   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (ready) begin
            seen = 1'b1;
            break;
         end
         if (stall) stalls++;
         @(negedge clk);
         if (i == 0) begin
            // operands are latched at launch; later changes must not matter
            src1 = $urandom;
            src2 = $urandom;
         end
      end
      chk("ready_seen", 32'(seen), 32'd1);
      chk("stall_cycles", 32'(stalls), (b == 32'd0) ? 32'd2 : 32'd33);
      chk("lo", lo, eq);
      chk("hi", hi, er);
      chk("stall_in_done", 32'(stall), 32'd0);
      last_lo = eq;
      last_hi = er;
      if (!keep) start = 1'b0;
      @(negedge clk);
      #1;
      chk("ready_pulse_width", 32'(ready), 32'd0);
   endtask

   initial begin
      int          pulses;
      logic [31:0] b;
      rst_n = 1'b0;
      start = 1'b0;
      sgn   = 1'b0;
      src1  = '0;
      src2  = '0;
      flush = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      do_op(1'b0, 32'd100, 32'd7, 1'b0);
      do_op(1'b1, -32'sd7, 32'd2, 1'b0);
      do_op(1'b1, 32'd7, -32'sd2, 1'b0);
      do_op(1'b0, 32'd5, 32'd0, 1'b0);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

      // flush in RUN with cnt == 10
      sgn   = 1'b0;
      src1  = 32'd1234567;
      src2  = 32'd89;
      start = 1'b1;
      repeat (11) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_stall", 32'(stall), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      #1;
      chk("flush_ready", 32'(ready), 32'd0);
      chk("flush_stall_after", 32'(stall), 32'd0);
      chk("flush_lo_held", lo, last_lo);
      chk("flush_hi_held", hi, last_hi);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (ready) pulses++;
      end
      chk("flush_no_result", 32'(pulses), 32'd0);
      chk("flush_lo_still", lo, last_lo);
      do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

      // asynchronous reset in the middle of RUN
      sgn   = 1'b1;
      src1  = 32'd999;
      src2  = 32'd3;
      start = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_ready", 32'(ready), 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      do_op(1'b1, -32'sd1000, 32'd7, 1'b1);
      do_op(1'b1, 32'd12345, -32'sd100, 1'b0);

      // randomized operations, some back-to-back
      for (int k = 0; k < 16; k++) begin
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         do_op(1'($urandom_range(0, 1)), $urandom, b, 1'($urandom_range(0, 1)));
      end
      start = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
